// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the byte-addressed data-memory port. Accepts one CPU
//   load/store at a time, issues word-aligned memory accesses with byte
//   enables, splits word-crossing accesses into two words, and returns
//   sign/zero-extended load data with a one-cycle completion pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V width/sign code (B, H, W, BU, HU)
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          illegal funct3 or disallowed misalignment
//   mem_addr          word-aligned memory address
//   mem_rd_en         read strobe
//   mem_wr_en         write strobe
//   mem_ctrl          byte enables, bit k selects byte mem_addr+k
//   mem_wdata         lane-aligned store data
//   mem_rdata         read data, valid the cycle after the read edge
//   mem_available     memory takes the access at this edge; low stalls
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_ctrl,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_available
);

    typedef enum logic [2:0] {
        IDLE, RD_A, CAP_A, RD_B, CAP_B, WR_A, WR_B, RESP
    } state_t;

    state_t state, state_next;

    // Request captured at accept
    logic        we_p0;
    logic [2:0]  f3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        split_p0;
    logic [31:0] lo_p0;

    // Response held until the next completion
    logic [31:0] rdata_p1;
    logic        err_p1;

    // Bytes touched, as a mask anchored at byte 0
    function automatic logic [3:0] width_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off == 2'd3;
            2'b10:   return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad_code, misaligned;
        bad_code   = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'd0));
        return bad_code || (!ALLOW_MISALIGNED && misaligned);
    endfunction

    // Shift the word pair down to the addressed byte, then extend
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [63:0] pair,
                                                input logic [1:0] off);
        logic [63:0] v;
        v = pair >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'd0, v[7:0]};
            3'b101:  return {16'd0, v[15:0]};
            default: return v[31:0];
        endcase
    endfunction

    logic        accept;
    logic        req_bad;
    logic [1:0]  off;
    logic [31:0] word0, word1;
    logic [7:0]  mask8;
    logic [63:0] data64;

    assign accept  = req_valid && (state == IDLE);
    assign req_bad = is_illegal(req_we, req_funct3, req_addr[1:0]);
    assign off     = addr_p0[1:0];
    assign word0   = {addr_p0[31:2], 2'b00};
    assign word1   = word0 + 32'd4;
    assign mask8   = {4'd0, width_mask(f3_p0)} << off;
    assign data64  = {32'd0, wdata_p0} << {off, 3'b000};

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_p1;
    assign resp_err   = err_p1;

    // Next state and memory-side decode, from registered state only
    always_comb begin
        state_next = state;
        mem_addr   = 32'd0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_ctrl   = 4'd0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE: begin
                if (req_valid) state_next = req_bad ? RESP : (req_we ? WR_A : RD_A);
            end
            RD_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = word0;
                mem_ctrl  = 4'b1111;
                if (mem_available) state_next = CAP_A;
            end
            CAP_A: state_next = split_p0 ? RD_B : RESP;
            RD_B: begin
                mem_rd_en = 1'b1;
                mem_addr  = word1;
                mem_ctrl  = 4'b1111;
                if (mem_available) state_next = CAP_B;
            end
            CAP_B: state_next = RESP;
            WR_A: begin
                mem_wr_en = 1'b1;
                mem_addr  = word0;
                mem_ctrl  = mask8[3:0];
                mem_wdata = data64[31:0];
                if (mem_available) state_next = split_p0 ? WR_B : RESP;
            end
            WR_B: begin
                mem_wr_en = 1'b1;
                mem_addr  = word1;
                mem_ctrl  = mask8[7:4];
                mem_wdata = data64[63:32];
                if (mem_available) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture stage: request fields and low read word
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            f3_p0    <= req_funct3;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            split_p0 <= crosses_word(req_funct3, req_addr[1:0]);
        end
        if (state == CAP_A) lo_p0 <= mem_rdata;
    end

    // Response stage: result latched on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rdata_p1 <= 32'd0;
            err_p1   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && req_bad) begin
                rdata_p1 <= 32'd0;
                err_p1   <= 1'b1;
            end else if (state == CAP_A && !split_p0) begin
                rdata_p1 <= load_extend(f3_p0, {32'd0, mem_rdata}, off);
                err_p1   <= 1'b0;
            end else if (state == CAP_B) begin
                rdata_p1 <= load_extend(f3_p0, {mem_rdata, lo_p0}, off);
                err_p1   <= 1'b0;
            end else if (we_p0 && state_next == RESP && (state == WR_A || state == WR_B)) begin
                rdata_p1 <= 32'd0;
                err_p1   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [3:0]  mem_ctrl;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_available = 1'b1;

    always #5 clk = ~clk;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_ctrl(mem_ctrl), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_available(mem_available)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // 256-byte memory; addresses alias modulo 256 so the top-of-space wrap lands at byte 0
    logic [7:0]  mem_b [256];
    logic [7:0]  ref_b [256];
    logic        init_mem = 1'b0;
    int          nrd = 0, nwr = 0, nstl = 0;
    logic [67:0] wr_log [16];
    logic [31:0] rd_log [16];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= ref_b[i];
        end else begin
            if (mem_available && mem_rd_en) begin
                mem_rdata <= {mem_b[{mem_addr[7:2], 2'd3}], mem_b[{mem_addr[7:2], 2'd2}],
                              mem_b[{mem_addr[7:2], 2'd1}], mem_b[{mem_addr[7:2], 2'd0}]};
                rd_log[nrd[3:0]] <= mem_addr;
                nrd <= nrd + 1;
            end
            if (mem_available && mem_wr_en) begin
                for (int k = 0; k < 4; k++)
                    if (mem_ctrl[k]) mem_b[{mem_addr[7:2], 2'(k)}] <= mem_wdata[8*k +: 8];
                wr_log[nwr[3:0]] <= {mem_addr, mem_ctrl, mem_wdata};
                nwr <= nwr + 1;
            end
            if ((mem_rd_en || mem_wr_en) && !mem_available) nstl <= nstl + 1;
        end
    end

    // Availability: targeted stalls on one address, else optional random stalls
    logic        rand_stall = 1'b0;
    int          stall_target = 0, stall_used = 0;
    logic [31:0] stall_addr = 32'd0;

    always @(posedge clk) begin
        #2;
        if (stall_used < stall_target && (mem_rd_en || mem_wr_en) && mem_addr == stall_addr) begin
            mem_available = 1'b0;
            stall_used++;
        end else if (rand_stall) begin
            mem_available = ($urandom_range(0, 3) != 0);
        end else begin
            mem_available = 1'b1;
        end
    end

    // While stalled, the presented access must not change
    logic        pend = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [5:0]  s_ctl;

    always @(negedge clk) begin
        if (pend && !rst) begin
            check_eq("stall_addr", mem_addr, s_addr);
            check_eq("stall_ctl", {26'd0, mem_ctrl, mem_rd_en, mem_wr_en}, {26'd0, s_ctl});
            check_eq("stall_wdata", mem_wdata, s_wdata);
        end
        pend    = !rst && (mem_rd_en || mem_wr_en) && !mem_available;
        s_addr  = mem_addr;
        s_ctl   = {mem_ctrl, mem_rd_en, mem_wr_en};
        s_wdata = mem_wdata;
    end

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic illegal(input logic we, input logic [2:0] f3);
        if (we) return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_b[b + 8'd3], ref_b[b + 8'd2], ref_b[b + 8'd1], ref_b[b]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {mem_b[b + 8'd3], mem_b[b + 8'd2], mem_b[b + 8'd1], mem_b[b]};
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        int          n, r0, w0, s0, base, exp_rd, exp_wr;
        logic        err, split, got;
        logic [31:0] exp_data;
        n        = size_of(f3);
        err      = illegal(we, f3);
        split    = (int'(addr[1:0]) + n) > 4;
        exp_data = 32'd0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++) exp_data |= 32'(ref_b[8'(addr + 32'(i))]) << (8 * i);
            if (f3 == 3'b000 && exp_data[7])  exp_data |= 32'hFFFF_FF00;
            if (f3 == 3'b001 && exp_data[15]) exp_data |= 32'hFFFF_0000;
        end
        base   = err ? 0 : (we ? (split ? 2 : 1) : (split ? 4 : 2));
        exp_rd = (err || we) ? 0 : (split ? 2 : 1);
        exp_wr = (err || !we) ? 0 : (split ? 2 : 1);

        @(negedge clk);
        for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
        check_eq("ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        r0 = nrd; w0 = nwr; s0 = nstl;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; break; end
            lat++;
        end
        check_eq("resp_seen", {31'd0, got}, 32'd1);
        check_eq("rdata", resp_rdata, exp_data);
        check_eq("err", {31'd0, resp_err}, {31'd0, err});
        check_eq("latency", lat, base + (nstl - s0));
        check_eq("reads", nrd - r0, exp_rd);
        check_eq("writes", nwr - w0, exp_wr);
        if (!err && we)
            for (int i = 0; i < n; i++) ref_b[8'(addr + 32'(i))] = wdata[8*i +: 8];
        @(negedge clk);
        check_eq("pulse", {31'd0, resp_valid}, 32'd0);
        check_eq("mem_w0", mem_word(addr), ref_word(addr));
        check_eq("mem_w1", mem_word(addr + 32'd4), ref_word(addr + 32'd4));
    endtask

    int          lat, w, r, pulses;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [31:0] a_r;

    initial begin
        for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
        ref_b[0] = 8'h11; ref_b[1] = 8'h22; ref_b[2] = 8'h33; ref_b[3] = 8'h44;
        ref_b[4] = 8'h55; ref_b[5] = 8'h66; ref_b[6] = 8'h77; ref_b[7] = 8'h88;
        init_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_mem", {26'd0, mem_ctrl, mem_rd_en, mem_wr_en}, 32'd0);
        check_eq("rst_maddr", mem_addr | mem_wdata, 32'd0);
        rst = 1'b0;

        // Aligned word load
        r = nrd;
        do_req(1'b0, 3'b010, 32'h100, 32'd0, lat);
        check_eq("lw_data", resp_rdata, 32'h4433_2211);
        check_eq("lw_addr", rd_log[r & 15], 32'h100);
        check_eq("lw_lat", lat, 2);

        // Misaligned word load across two words
        r = nrd;
        do_req(1'b0, 3'b010, 32'h102, 32'd0, lat);
        check_eq("lw2_data", resp_rdata, 32'h6655_4433);
        check_eq("lw2_rdA", rd_log[r & 15], 32'h100);
        check_eq("lw2_rdB", rd_log[(r + 1) & 15], 32'h104);
        check_eq("lw2_lat", lat, 4);

        // Byte loads of 0x80 at offset 3
        do_req(1'b1, 3'b000, 32'h103, 32'h0000_0080, lat);
        r = nrd;
        do_req(1'b0, 3'b000, 32'h103, 32'd0, lat);
        check_eq("lb_data", resp_rdata, 32'hFFFF_FF80);
        check_eq("lb_addr", rd_log[r & 15], 32'h100);
        do_req(1'b0, 3'b100, 32'h103, 32'd0, lat);
        check_eq("lbu_data", resp_rdata, 32'h0000_0080);

        // Halfword store split over two words
        w = nwr;
        do_req(1'b1, 3'b001, 32'h103, 32'h0000_BEEF, lat);
        check_eq("sh_A_addr", wr_log[w & 15][67:36], 32'h100);
        check_eq("sh_A_ctrl", {28'd0, wr_log[w & 15][35:32]}, 32'b1000);
        check_eq("sh_A_data", wr_log[w & 15][31:0], 32'hEF00_0000);
        check_eq("sh_B_addr", wr_log[(w + 1) & 15][67:36], 32'h104);
        check_eq("sh_B_ctrl", {28'd0, wr_log[(w + 1) & 15][35:32]}, 32'b0001);
        check_eq("sh_B_data", wr_log[(w + 1) & 15][31:0], 32'h0000_00BE);
        check_eq("sh_lat", lat, 2);

        // Three stall cycles on the second read
        stall_addr   = 32'h104;
        stall_target = stall_used + 3;
        do_req(1'b0, 3'b010, 32'h102, 32'd0, lat);
        check_eq("stall_lat", lat, 7);
        stall_target = stall_used;

        // Illegal funct3
        do_req(1'b0, 3'b011, 32'h100, 32'd0, lat);
        check_eq("err_flag", {31'd0, resp_err}, 32'd1);
        check_eq("err_lat", lat, 0);
        do_req(1'b1, 3'b100, 32'h108, 32'h1234_5678, lat);
        check_eq("err_st", {31'd0, resp_err}, 32'd1);

        // Reset while the second read is pending
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_rd_en && mem_addr == 32'h104) break;
        end
        check_eq("rstmid_rdB", mem_addr, 32'h104);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstmid_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rstmid_strobe", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check_eq("rstmid_pulse", pulses, 0);

        // Randomized traffic with random stalls, including the top-of-space wrap
        rand_stall = 1'b1;
        for (int t = 0; t < 150; t++) begin
            we_r = 1'($urandom);
            f3_r = 3'($urandom_range(0, 7));
            a_r  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                              : 32'($urandom_range(0, 255));
            do_req(we_r, f3_r, a_r, $urandom, lat);
        end
        rand_stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
